// File: rtl/jtag_seq_pkg.sv
// Shared types and TMS walk constants for the JTAG shift sequencer.
package jtag_seq_pkg;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    NAV,
    SHIFT,
    EXIT,
    RESP
  } seq_state_t;

  // TMS walks from Run-Test/Idle to Shift-xR, bit 0 sent first
  localparam logic [2:0] NAV_DR_TMS = 3'b001;
  localparam int         NAV_DR_LEN = 3;
  localparam logic [3:0] NAV_IR_TMS = 4'b0011;
  localparam int         NAV_IR_LEN = 4;

  localparam int INIT_TLR_CYCLES = 5;

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK generator: half-period counter, TCK register and rise/fall strobes.
module jtag_tck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tck,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt;
  logic             term;

  // Strobes mark the clk cycle whose closing edge toggles TCK
  assign term = en && (cnt == CNT_W'(CLK_DIV - 1));
  assign rise = term && !tck;
  assign fall = term && tck;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (term) begin
      cnt <= '0;
      tck <= ~tck;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/jtag_shift_sequencer.sv
// Host-side JTAG master running IR/DR scans from one system clock.
// Optional macro JTAG_SEQ_TLR_CMD_EN adds cmd_tlr (Test-Logic-Reset command).
module jtag_shift_sequencer
  import jtag_seq_pkg::*;
#(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 5,
  parameter int CLK_DIV = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_ir,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
`ifdef JTAG_SEQ_TLR_CMD_EN
  input  logic               cmd_tlr,
`endif
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               busy,
  output logic               TCK,
  output logic               TMS,
  output logic               TDI,
  input  logic               TDO
);

  seq_state_t         state;
  logic [2:0]         step;
  logic [2:0]         step_nxt;
  logic [LEN_W-1:0]   bit_cnt;
  logic [LEN_W-1:0]   bit_nxt;
  logic [LEN_W-1:0]   len_q;
  logic [MAX_LEN-1:0] data_q;
  logic               ir_q;
  logic               tlr_q;
  logic               tdi_pre;
  logic [3:0]         nav_pat;
  logic [2:0]         nav_last;
  logic               tck_en;
  logic               tck_rise;
  logic               tck_fall;
  logic               tlr_req;
  logic               accept;

  function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] l);
    if (int'(l) > MAX_LEN - 1) sat_len = LEN_W'(MAX_LEN - 1);
    else                       sat_len = l;
  endfunction

`ifdef JTAG_SEQ_TLR_CMD_EN
  assign tlr_req = cmd_tlr;
`else
  assign tlr_req = 1'b0;
`endif

  assign accept   = cmd_valid && cmd_ready;
  assign busy     = ~cmd_ready;
  assign tck_en   = (state != IDLE) && (state != RESP);
  assign nav_pat  = ir_q ? NAV_IR_TMS : {1'b0, NAV_DR_TMS};
  assign nav_last = ir_q ? 3'(NAV_IR_LEN - 1) : 3'(NAV_DR_LEN - 1);
  assign step_nxt = step + 3'd1;
  assign bit_nxt  = bit_cnt + 1'b1;

  jtag_tck_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tck_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (tck_en),
    .tck  (TCK),
    .rise (tck_rise),
    .fall (tck_fall)
  );

  // Command payload and the next TDI bit, picked on the rising edge so the
  // falling-edge update is a plain register move
  always_ff @(posedge clk) begin
    if (accept) begin
      ir_q   <= cmd_ir;
      len_q  <= sat_len(cmd_len);
      data_q <= cmd_data;
    end
    if (state == SHIFT && tck_rise) tdi_pre <= data_q[bit_nxt];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      step      <= '0;
      bit_cnt   <= '0;
      TMS       <= 1'b1;
      TDI       <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      tlr_q     <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        INIT: if (tck_fall) begin
          if (step == 3'(INIT_TLR_CYCLES)) begin
            step <= '0;
            if (tlr_q) begin
              tlr_q     <= 1'b0;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              cmd_ready <= 1'b1;
              state     <= IDLE;
            end
          end else begin
            step <= step_nxt;
            TMS  <= (step_nxt != 3'(INIT_TLR_CYCLES));
          end
        end
        IDLE: if (accept) begin
          cmd_ready <= 1'b0;
          rsp_data  <= '0;
          step      <= '0;
          TMS       <= 1'b1;
          if (tlr_req) begin
            tlr_q <= 1'b1;
            state <= INIT;
          end else begin
            state <= NAV;
          end
        end
        NAV: if (tck_fall) begin
          if (step == nav_last) begin
            bit_cnt <= '0;
            TDI     <= data_q[0];
            TMS     <= (len_q == '0);
            state   <= SHIFT;
          end else begin
            step <= step_nxt;
            TMS  <= nav_pat[step_nxt[1:0]];
          end
        end
        SHIFT: if (tck_fall) begin
          rsp_data[bit_cnt] <= TDO;
          if (bit_cnt == len_q) begin
            step  <= '0;
            TMS   <= 1'b1;
            TDI   <= 1'b0;
            state <= EXIT;
          end else begin
            bit_cnt <= bit_nxt;
            TDI     <= tdi_pre;
            TMS     <= (bit_nxt == len_q);
          end
        end
        // Exit1 -> Update-xR (TMS=1), then Update-xR -> Run-Test/Idle (TMS=0)
        EXIT: if (tck_fall) begin
          if (step == '0) begin
            step <= 3'd1;
            TMS  <= 1'b0;
          end else begin
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_shift_sequencer.sv
// Self-checking bench for jtag_shift_sequencer against a behavioural TAP model.
module tb_jtag_shift_sequencer;

  localparam int MAX_LEN = 32;
  localparam int LEN_W   = 5;
  localparam int CLK_DIV = 4;
  localparam int PER     = 2 * CLK_DIV;
  localparam int BUDGET  = 3000;
  localparam logic [31:0] IDCODE_VAL = 32'h1234_5679;
  localparam logic [3:0]  IR_IDCODE  = 4'h1;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic               cmd_ir = 1'b0;
  logic [LEN_W-1:0]   cmd_len = '0;
  logic [MAX_LEN-1:0] cmd_data = '0;
`ifdef JTAG_SEQ_TLR_CMD_EN
  logic               cmd_tlr = 1'b0;
`endif
  logic               rsp_valid;
  logic [MAX_LEN-1:0] rsp_data;
  logic               busy;
  logic               tck, tms, tdi;
  logic               tdo_r = 1'b0;

  always #5 clk = ~clk;

  jtag_shift_sequencer #(
    .MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CLK_DIV(CLK_DIV)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_ir   (cmd_ir),
    .cmd_len  (cmd_len),
    .cmd_data (cmd_data),
`ifdef JTAG_SEQ_TLR_CMD_EN
    .cmd_tlr  (cmd_tlr),
`endif
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .busy     (busy),
    .TCK      (tck),
    .TMS      (tms),
    .TDI      (tdi),
    .TDO      (tdo_r)
  );

  // TAP model with a 4-bit IR, IDCODE and BYPASS; TDO registered on TCK rise
  typedef enum logic [3:0] {
    TLR, RTI, SDR, CDR, SHDR, E1DR, PDR, E2DR, UDR,
    SIR, CIR, SHIR, E1IR, PIR, E2IR, UIR
  } tap_t;

  tap_t        tap_st = TLR;
  logic [3:0]  ir_reg = IR_IDCODE;
  logic [3:0]  ir_sr = '0;
  logic [31:0] id_sr = '0;
  logic        byp = 1'b0;

  function automatic tap_t tap_next(input tap_t s, input logic m);
    case (s)
      TLR:  return m ? TLR  : RTI;
      RTI:  return m ? SDR  : RTI;
      SDR:  return m ? SIR  : CDR;
      CDR:  return m ? E1DR : SHDR;
      SHDR: return m ? E1DR : SHDR;
      E1DR: return m ? UDR  : PDR;
      PDR:  return m ? E2DR : PDR;
      E2DR: return m ? UDR  : SHDR;
      UDR:  return m ? SDR  : RTI;
      SIR:  return m ? TLR  : CIR;
      CIR:  return m ? E1IR : SHIR;
      SHIR: return m ? E1IR : SHIR;
      E1IR: return m ? UIR  : PIR;
      PIR:  return m ? E2IR : PIR;
      E2IR: return m ? UIR  : SHIR;
      default: return m ? SDR : RTI;
    endcase
  endfunction

  always @(posedge tck) begin
    case (tap_st)
      TLR: ir_reg <= IR_IDCODE;
      CDR: begin id_sr <= IDCODE_VAL; byp <= 1'b0; end
      SHDR:
        if (ir_reg == IR_IDCODE) begin
          tdo_r <= id_sr[0];
          id_sr <= {tdi, id_sr[31:1]};
        end else begin
          tdo_r <= byp;
          byp   <= tdi;
        end
      CIR:  ir_sr <= 4'b0001;
      SHIR: begin tdo_r <= ir_sr[0]; ir_sr <= {tdi, ir_sr[3:1]}; end
      UIR:  ir_reg <= ir_sr;
      default: ;
    endcase
    tap_st <= tap_next(tap_st, tms);
  end

  // Per-TCK-rise log of TMS/TDI, clk edge counter, response log
  logic tms_log [1024];
  logic tdi_log [1024];
  int   nrise = 0;
  int   cyc = 0;
  int   rsp_cyc_q[$];
  logic [31:0] rsp_dat_q[$];

  always @(posedge tck) begin
    if (nrise < 1024) begin
      tms_log[nrise] <= tms;
      tdi_log[nrise] <= tdi;
    end
    nrise <= nrise + 1;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rsp_valid) begin
      rsp_cyc_q.push_back(cyc);
      rsp_dat_q.push_back(rsp_data);
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_rsp(input int p0, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      if (rsp_cyc_q.size() > p0) begin ok = 1'b1; break; end
    end
  endtask

  typedef struct {
    logic             ir;
    logic [LEN_W-1:0] len;
    logic [31:0]      data;
    logic [31:0]      rsp;
    int               n;     // TCK periods from handshake to response
    logic [63:0]      tms;   // TMS seen at each TCK rise, bit 0 first
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input int idx, input vec_t v);
    bit          ok;
    int          r0, p0, hs, nav;
    logic [63:0] tms_act;
    logic [31:0] tdi_act, mask;
    string       nm;
    nm = $sformatf("v%0d", idx);
    wait_ready(ok);
    check({nm, "_ready"}, 64'(ok), 64'd1);
    r0 = nrise;
    p0 = rsp_cyc_q.size();
    cmd_ir    = v.ir;
    cmd_len   = v.len;
    cmd_data  = v.data;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    hs = cyc;
    cmd_valid = 1'b0;
    wait_rsp(p0, ok);
    repeat (4) @(negedge clk);
    check({nm, "_rsp_count"}, 64'(rsp_cyc_q.size()), 64'(p0 + 1));
    if (ok) begin
      check({nm, "_rsp_data"}, 64'(rsp_dat_q[p0]), 64'(v.rsp));
      check({nm, "_latency"}, 64'(rsp_cyc_q[p0] - hs), 64'(PER * v.n));
    end
    check({nm, "_tck_count"}, 64'(nrise - r0), 64'(v.n));
    tms_act = '0;
    for (int j = 0; j < v.n && j < 64; j++) tms_act[j] = tms_log[r0 + j];
    check({nm, "_tms"}, tms_act, v.tms);
    nav = v.ir ? 4 : 3;
    tdi_act = '0;
    for (int j = 0; j <= int'(v.len); j++) tdi_act[j] = tdi_log[r0 + nav + j];
    mask = (v.len == 5'd31) ? 32'hFFFF_FFFF : ((32'd1 << (int'(v.len) + 1)) - 32'd1);
    check({nm, "_tdi"}, 64'(tdi_act), 64'(v.data & mask));
  endtask

  task automatic release_and_init(input string nm);
    bit ok;
    int c0, r0;
    @(negedge clk);
    rst_n = 1'b1;
    c0 = cyc;
    r0 = nrise;
    wait_ready(ok);
    check({nm, "_ready"}, 64'(ok), 64'd1);
    check({nm, "_ready_cycles"}, 64'(cyc - c0), 64'(6 * PER));
    check({nm, "_tck_count"}, 64'(nrise - r0), 64'd6);
    check({nm, "_tms"}, {58'd0, tms_log[r0+5], tms_log[r0+4], tms_log[r0+3],
                         tms_log[r0+2], tms_log[r0+1], tms_log[r0]}, 64'h1F);
    check({nm, "_tap_rti"}, 64'(tap_st == RTI), 64'd1);
    check({nm, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    bit ok;
    int r0, p0, hs1, hs2;

    //                 ir    len    data          rsp            n   tms
    vecs[0] = '{1'b1, 5'd3,  32'h7,        32'h1,        10, 64'h183};
    vecs[1] = '{1'b0, 5'd3,  32'hA,        32'h4,        9,  64'hC1};
    vecs[2] = '{1'b1, 5'd3,  32'h1,        32'h1,        10, 64'h183};
    vecs[3] = '{1'b0, 5'd31, 32'h0,        IDCODE_VAL,   37, 64'hC_0000_0001};
    vecs[4] = '{1'b0, 5'd0,  32'h1,        32'h1,        6,  64'h19};
    vecs[5] = '{1'b0, 5'd7,  32'hFF,       32'h79,       13, 64'hC01};

    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_tck", 64'(tck), 64'd0);
    check("rst_tms", 64'(tms), 64'd1);
    check("rst_tdi", 64'(tdi), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    release_and_init("init");

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Reset in the middle of a 32-bit DR scan, during shift bit 10
    wait_ready(ok);
    r0 = nrise;
    p0 = rsp_cyc_q.size();
    cmd_ir = 1'b0; cmd_len = 5'd31; cmd_data = 32'hDEAD_BEEF; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      if (nrise >= r0 + 3 + 11) begin ok = 1'b1; break; end
    end
    check("midrst_reached_bit10", 64'(ok), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_tck", 64'(tck), 64'd0);
    check("midrst_tms", 64'(tms), 64'd1);
    check("midrst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("midrst_busy", 64'(busy), 64'd1);
    check("midrst_rsp_data", 64'(rsp_data), 64'd0);
    repeat (3) @(negedge clk);
    release_and_init("midrst_init");
    repeat (4) @(negedge clk);
    check("midrst_no_rsp", 64'(rsp_cyc_q.size()), 64'(p0));
    check("midrst_ir_idcode", 64'(ir_reg), 64'(IR_IDCODE));
    run_vec(6, vecs[3]);

    // Back-to-back: cmd_valid held; second command taken in the IDLE cycle after RESP
    wait_ready(ok);
    p0 = rsp_cyc_q.size();
    cmd_ir = 1'b0; cmd_len = 5'd7; cmd_data = 32'hFF; cmd_valid = 1'b1;
    @(posedge clk);
    #1 hs1 = cyc;
    cmd_ir = 1'b1; cmd_len = 5'd3; cmd_data = 32'hF;
    wait_ready(ok);
    check("b2b_ready", 64'(ok), 64'd1);
    check("b2b_hold_rsp_data", 64'(rsp_data), 64'h79);
    @(posedge clk);
    #1 hs2 = cyc;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("b2b_rsp_cleared", 64'(rsp_data), 64'd0);
    check("b2b_first_count", 64'(rsp_cyc_q.size()), 64'(p0 + 1));
    if (rsp_cyc_q.size() > p0) begin
      check("b2b_first_data", 64'(rsp_dat_q[p0]), 64'h79);
      check("b2b_first_latency", 64'(rsp_cyc_q[p0] - hs1), 64'(PER * 13));
      check("b2b_gap", 64'(hs2 - rsp_cyc_q[p0]), 64'd2);
    end
    wait_rsp(p0 + 1, ok);
    check("b2b_second_seen", 64'(ok), 64'd1);
    if (ok) begin
      check("b2b_second_data", 64'(rsp_dat_q[p0+1]), 64'h1);
      check("b2b_second_latency", 64'(rsp_cyc_q[p0+1] - hs2), 64'(PER * 10));
    end

`ifdef JTAG_SEQ_TLR_CMD_EN
    // Test-Logic-Reset command: INIT rerun, then an all-zero response
    wait_ready(ok);
    p0 = rsp_cyc_q.size();
    cmd_tlr = 1'b1; cmd_ir = 1'b1; cmd_len = 5'd3; cmd_data = 32'hF; cmd_valid = 1'b1;
    @(posedge clk);
    #1 hs1 = cyc;
    cmd_valid = 1'b0; cmd_tlr = 1'b0;
    wait_rsp(p0, ok);
    check("tlr_seen", 64'(ok), 64'd1);
    if (ok) begin
      check("tlr_data", 64'(rsp_dat_q[p0]), 64'd0);
      check("tlr_latency", 64'(rsp_cyc_q[p0] - hs1), 64'(PER * 6));
    end
    check("tlr_ir_idcode", 64'(ir_reg), 64'(IR_IDCODE));
`endif

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
